// File: rtl/vball_oki_if.sv
// Sound-CPU and sample-ROM bus for the vball OKI ADPCM player.
// slave: the player; master: the CPU decode plus the ROM it reads.
interface vball_oki_if #(
  parameter int ROM_AW = 17
);
  logic              cs;
  logic              we;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;

  modport slave  (input cs, we, din, rom_data, output dout, rom_addr);
  modport master (output cs, we, din, rom_data, input dout, rom_addr);
endinterface

// File: rtl/vball_oki.sv
// vball_oki: MSM6295-style 4-voice ADPCM player fed from the OKI sample ROM.
// Sequencer: IDLE -> PHRASE -> IDLE, or IDLE -> per-voice FETCH/WAIT/DECODE -> MIX -> IDLE.
// Build option: define VBALL_OKI_FILTER_EN for a 1-pole low-pass on the mixed output.
module vball_oki #(
  parameter int ROM_AW = 17
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               sample_cen,
  vball_oki_if.slave         bus,
  output logic signed [15:0] sample
);

  typedef enum logic [2:0] {
    S_IDLE, S_PHRASE, S_FETCH, S_WAIT, S_DECODE, S_MIX
  } state_t;

  localparam logic [10:0] STEP_TBL [49] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
    11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
    11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
    11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
    11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
    11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
    11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
  };

  function automatic logic [5:0] gain_of(input logic [3:0] a);
    case (a)
      4'd0:    gain_of = 6'd32;
      4'd1:    gain_of = 6'd22;
      4'd2:    gain_of = 6'd16;
      4'd3:    gain_of = 6'd11;
      4'd4:    gain_of = 6'd8;
      4'd5:    gain_of = 6'd5;
      4'd6:    gain_of = 6'd4;
      4'd7:    gain_of = 6'd3;
      4'd8:    gain_of = 6'd2;
      default: gain_of = 6'd0;
    endcase
  endfunction

  state_t            state;
  logic              wr_q;
  logic              cmd_phase;
  logic [6:0]        phrase;
  logic              q_valid;
  logic [6:0]        q_phrase;
  logic [3:0]        q_mask;
  logic [3:0]        q_atten;
  logic              tick_pend;
  logic [1:0]        cv;
  logic [2:0]        bcnt;
  logic              pwait;
  logic [ROM_AW-1:0] st_q;
  logic [ROM_AW-1:0] en_q;

  logic [3:0]               busy;
  logic [3:0]               live;
  logic [3:0]               nib_hi;
  logic [ROM_AW-1:0]        addr     [4];
  logic [ROM_AW-1:0]        end_addr [4];
  logic signed [11:0]       sig      [4];
  logic [5:0]               step_idx [4];
  logic [3:0]               atten    [4];

  logic              wr_edge;
  logic [3:0]        stop_mask;
  logic [3:0]        start_mask;
  logic [ROM_AW-1:0] en_full;
  logic [3:0]        nib;
  logic [10:0]       step;
  logic [11:0]       diff;
  logic signed [13:0] sig_ext;
  logic signed [13:0] sig_sum;
  logic signed [11:0] sig_new;
  logic signed [7:0]  idx_sum;
  logic [5:0]         idx_new;
  logic signed [19:0] acc;
  logic signed [15:0] mix_out;
`ifdef VBALL_OKI_FILTER_EN
  logic signed [16:0] fdiff;
  logic signed [15:0] filt_step;
`endif

  // CPU status read; zero when not addressed so the read bus can be OR-ed
  always_comb begin
    bus.dout = (bus.cs && !bus.we) ? {4'hF, busy} : 8'd0;
  end

  // Command decode from the write rising edge
  always_comb begin
    wr_edge    = bus.cs && bus.we && !wr_q;
    stop_mask  = (wr_edge && !cmd_phase && !bus.din[7]) ? bus.din[6:3] : 4'd0;
    start_mask = bus.din[7:4] & ~busy;
    en_full    = ROM_AW'({en_q, bus.rom_data});
  end

  // ADPCM decode of the current voice's nibble
  always_comb begin
    nib     = nib_hi[cv] ? bus.rom_data[7:4] : bus.rom_data[3:0];
    step    = STEP_TBL[step_idx[cv]];
    diff    = {4'd0, step[10:3]}
            + (nib[0] ? {3'd0, step[10:2]} : 12'd0)
            + (nib[1] ? {2'd0, step[10:1]} : 12'd0)
            + (nib[2] ? {1'b0, step}       : 12'd0);
    sig_ext = {{2{sig[cv][11]}}, sig[cv]};
    sig_sum = nib[3] ? sig_ext - $signed({2'b00, diff})
                     : sig_ext + $signed({2'b00, diff});
    if (sig_sum > 14'sd2047)        sig_new = 12'sd2047;
    else if (sig_sum < -14'sd2048)  sig_new = -12'sd2048;
    else                            sig_new = sig_sum[11:0];
    idx_sum = $signed({2'b00, step_idx[cv]})
            + (nib[2] ? ($signed({5'd0, nib[1:0], 1'b0}) + 8'sd2) : -8'sd1);
    if (idx_sum < 8'sd0)       idx_new = 6'd0;
    else if (idx_sum > 8'sd48) idx_new = 6'd48;
    else                       idx_new = idx_sum[5:0];
  end

  // Attenuated mix of the voices decoded this tick
  always_comb begin
    acc = '0;
    for (int unsigned v = 0; v < 4; v++) begin
      if (live[v])
        acc = acc + ({{8{sig[v][11]}}, sig[v]} * {14'd0, gain_of(atten[v])});
    end
    mix_out = 16'(acc >>> 4);
`ifdef VBALL_OKI_FILTER_EN
    fdiff     = $signed({mix_out[15], mix_out}) - $signed({sample[15], sample});
    filt_step = 16'(fdiff >>> 2);
`endif
  end

  // Sequencer, voice state and command handling
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= S_IDLE;
      wr_q         <= 1'b0;
      cmd_phase    <= 1'b0;
      phrase       <= '0;
      q_valid      <= 1'b0;
      q_phrase     <= '0;
      q_mask       <= '0;
      q_atten      <= '0;
      tick_pend    <= 1'b0;
      cv           <= '0;
      bcnt         <= '0;
      pwait        <= 1'b0;
      st_q         <= '0;
      en_q         <= '0;
      busy         <= '0;
      live         <= '0;
      nib_hi       <= '1;
      sample       <= '0;
      bus.rom_addr <= '0;
      for (int unsigned v = 0; v < 4; v++) begin
        addr[v]     <= '0;
        end_addr[v] <= '0;
        sig[v]      <= '0;
        step_idx[v] <= '0;
        atten[v]    <= '0;
      end
    end else begin
      wr_q <= bus.cs && bus.we;
      if (sample_cen && state != S_IDLE) tick_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          // a sample tick always wins over a queued phrase load
          if (sample_cen || tick_pend) begin
            tick_pend <= 1'b0;
            live      <= '0;
            cv        <= '0;
            state     <= S_FETCH;
          end else if (q_valid) begin
            bus.rom_addr <= ROM_AW'({q_phrase, 3'b000});
            bcnt         <= '0;
            pwait        <= 1'b1;
            state        <= S_PHRASE;
          end
        end
        S_PHRASE: begin
          // two cycles per byte: address out, then data back
          if (pwait) begin
            pwait <= 1'b0;
          end else if (bcnt == 3'd5) begin
            for (int unsigned v = 0; v < 4; v++) begin
              if (q_mask[v] && !busy[v]) begin
                addr[v]     <= st_q;
                end_addr[v] <= en_full;
                nib_hi[v]   <= 1'b1;
                sig[v]      <= '0;
                step_idx[v] <= '0;
                atten[v]    <= q_atten;
                busy[v]     <= 1'b1;
              end
            end
            q_valid <= 1'b0;
            state   <= S_IDLE;
          end else begin
            if (bcnt < 3'd3) st_q <= ROM_AW'({st_q, bus.rom_data});
            else             en_q <= ROM_AW'({en_q, bus.rom_data});
            bcnt         <= bcnt + 3'd1;
            bus.rom_addr <= bus.rom_addr + 1'b1;
            pwait        <= 1'b1;
          end
        end
        S_FETCH: begin
          if (busy[cv]) begin
            bus.rom_addr <= addr[cv];
            state        <= S_WAIT;
          end else if (cv == 2'd3) begin
            state <= S_MIX;
          end else begin
            cv <= cv + 2'd1;
          end
        end
        S_WAIT: state <= S_DECODE;
        S_DECODE: begin
          if (busy[cv]) begin
            sig[cv]      <= sig_new;
            step_idx[cv] <= idx_new;
            live[cv]     <= 1'b1;
            if (nib_hi[cv]) begin
              nib_hi[cv] <= 1'b0;
            end else begin
              nib_hi[cv] <= 1'b1;
              if (addr[cv] == end_addr[cv]) busy[cv] <= 1'b0;
              else                          addr[cv] <= addr[cv] + 1'b1;
            end
          end
          if (cv == 2'd3) state <= S_MIX;
          else begin
            cv    <= cv + 2'd1;
            state <= S_FETCH;
          end
        end
        S_MIX: begin
`ifdef VBALL_OKI_FILTER_EN
          sample <= sample + filt_step;
`else
          sample <= mix_out;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // commands come last so a stop overrides a same-cycle decode or phrase start
      if (wr_edge) begin
        if (!cmd_phase) begin
          if (bus.din[7]) begin
            phrase    <= bus.din[6:0];
            cmd_phase <= 1'b1;
          end
        end else begin
          cmd_phase <= 1'b0;
          if (phrase != 7'd0 && start_mask != 4'd0) begin
            q_valid  <= 1'b1;
            q_phrase <= phrase;
            q_mask   <= start_mask;
            q_atten  <= bus.din[3:0];
          end
        end
      end
      for (int unsigned v = 0; v < 4; v++) begin
        if (stop_mask[v]) begin
          busy[v]   <= 1'b0;
          live[v]   <= 1'b0;
          q_mask[v] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vball_oki.sv
// Directed bench for vball_oki: synchronous ROM model, table of per-tick
// expected samples for a hand-decoded phrase, plus start/stop/reset sequences.
module tb_vball_oki;

  logic               clk_sys = 1'b0;
  logic               reset;
  logic               sample_cen;
  logic signed [15:0] sample;
  logic [7:0]         rom [0:131071];
  logic [7:0]         st;
  int                 n_checks = 0;
  int                 n_err = 0;

  typedef struct {
    logic [15:0] exp_sample;
    logic [7:0]  exp_stat;
  } vec_t;
  vec_t vecs [9];

  vball_oki_if #(.ROM_AW(17)) bus ();

  vball_oki #(.ROM_AW(17)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .sample_cen (sample_cen),
    .bus        (bus.slave),
    .sample     (sample)
  );

  always #5 clk_sys = ~clk_sys;

  // ROM data appears one clock after the address
  always @(posedge clk_sys) bus.rom_data <= rom[bus.rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    @(posedge clk_sys); #1;
    bus.cs = 1'b1; bus.we = 1'b1; bus.din = b;
    @(posedge clk_sys); #1;
    bus.cs = 1'b0; bus.we = 1'b0; bus.din = 8'h00;
  endtask

  task automatic rd(output logic [7:0] v);
    @(posedge clk_sys); #1;
    bus.cs = 1'b1; bus.we = 1'b0;
    @(negedge clk_sys);
    v = bus.dout;
    @(posedge clk_sys); #1;
    bus.cs = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_sys); #1;
    sample_cen = 1'b1;
    @(posedge clk_sys); #1;
    sample_cen = 1'b0;
    repeat (60) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic settle();
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) rom[i] = 8'h00;
    // phrase 1: 0x400..0x403, phrase 2: 0x800..0x81F
    rom[8]  = 8'h00; rom[9]  = 8'h04; rom[10] = 8'h00;
    rom[11] = 8'h00; rom[12] = 8'h04; rom[13] = 8'h03;
    rom[16] = 8'h00; rom[17] = 8'h08; rom[18] = 8'h00;
    rom[19] = 8'h00; rom[20] = 8'h08; rom[21] = 8'h1F;
    rom[12'h400] = 8'h77; rom[12'h401] = 8'h70;
    rom[12'h402] = 8'h08; rom[12'h403] = 8'h31;
    for (int i = 12'h800; i < 12'h820; i++) rom[i] = 8'h77;

    // nibbles 7,7,7,0,0,8,3,1 from signal 0 / step index 0, gain 32: sample = 2*signal
    vecs[0] = '{16'h003C, 8'hF1};  // 30
    vecs[1] = '{16'h00BA, 8'hF1};  // 93
    vecs[2] = '{16'h01CA, 8'hF1};  // 229
    vecs[3] = '{16'h01F0, 8'hF1};  // 248
    vecs[4] = '{16'h0212, 8'hF1};  // 265
    vecs[5] = '{16'h01F2, 8'hF1};  // 249
    vecs[6] = '{16'h02BE, 8'hF1};  // 351
    vecs[7] = '{16'h030C, 8'hF0};  // 390, last nibble at end address
    vecs[8] = '{16'h0000, 8'hF0};  // voice idle

    reset = 1'b1; sample_cen = 1'b0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.din = 8'h00;
    repeat (3) @(posedge clk_sys); #1;
    reset = 1'b0;
    @(negedge clk_sys);
    chk("reset_sample", sample, 16'h0000);
    chk("reset_dout", bus.dout, 8'h00);
    chk("reset_rom_addr", bus.rom_addr, 17'h0);
    rd(st); chk("reset_status", st, 8'hF0);

    // phrase 0 is consumed without starting anything
    wr(8'h80); wr(8'h10); settle();
    rd(st); chk("phrase0_status", st, 8'hF0);

    // full playback of phrase 1 on voice 0
    wr(8'h81); wr(8'h10); settle();
    rd(st); chk("start_status", st, 8'hF1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("play_sample[%0d]", i), sample, vecs[i].exp_sample);
      rd(st);
      chk($sformatf("play_status[%0d]", i), st, vecs[i].exp_stat);
    end

    // restart while busy is ignored, then stop mid-phrase
    wr(8'h81); wr(8'h10); settle();
    tick(); chk("restart_t0", sample, 16'h003C);
    wr(8'h81); wr(8'h10); settle();
    rd(st); chk("restart_busy", st, 8'hF1);
    tick(); chk("restart_t1", sample, 16'h00BA);
    tick(); chk("restart_t2", sample, 16'h01CA);
    wr(8'h08);
    rd(st); chk("stop_status", st, 8'hF0);
    tick(); chk("stop_sample", sample, 16'h0000);

    // attenuation 2 (gain 16) and 9 (muted)
    wr(8'h81); wr(8'h12); settle();
    tick(); chk("atten2_sample", sample, 16'h001E);
    wr(8'h08);
    wr(8'h81); wr(8'h19); settle();
    tick(); chk("atten9_sample", sample, 16'h0000);
    rd(st); chk("atten9_status", st, 8'hF1);
    wr(8'h08);

    // saturation: 2 voices at 2047*32 -> 0x1FFC, then 4 voices -> 0x3FF8
    wr(8'h82); wr(8'h30); settle();
    repeat (10) tick();
    chk("sat2_sample", sample, 16'h1FFC);
    rd(st); chk("sat2_status", st, 8'hF3);
    wr(8'h82); wr(8'hC0); settle();
    repeat (10) tick();
    chk("sat4_sample", sample, 16'h3FF8);
    rd(st); chk("sat4_status", st, 8'hFF);
    wr(8'h78);
    rd(st); chk("stopall_status", st, 8'hF0);
    tick(); chk("stopall_sample", sample, 16'h0000);

    // reset while the phrase table is being read
    wr(8'h81); wr(8'h10); settle();
    tick(); chk("prereset_sample", sample, 16'h003C);
    wr(8'h82); wr(8'h20);
    repeat (5) @(posedge clk_sys); #1;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(negedge clk_sys);
    chk("midreset_dout", bus.dout, 8'h00);
    chk("midreset_sample", sample, 16'h0000);
    settle();
    chk("midreset_rom_addr", bus.rom_addr, 17'h0);
    rd(st); chk("midreset_status", st, 8'hF0);
    wr(8'h82); wr(8'h20); settle();
    rd(st); chk("v1_status", st, 8'hF2);
    tick(); chk("v1_sample", sample, 16'h003C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
